mul_axis_tx: RTL and testbench
==============================

// Module: mul_axis_tx
// PURPOSE
//  Output-side transmitter for the 3-stage pipelined 8x8 multiplier (en/a/b in, p/valid out, no backpressure).
//  - Takes each product on the multiplier's valid/product outputs and buffers it in a small FIFO.
//  - Sends the buffered products as an AXI4-Stream master with fixed-length packets.
//  - Issues credits upstream so the driver raises en only when every in-flight product has a guaranteed FIFO slot.
// PARAMETERS
//  DEPTH    4   FIFO entries; power of two, >= PIPE_LAT+1
//  PKT_LEN  8   beats per packet; tlast on beat PKT_LEN-1; range 1..256
//  DATA_W   16  product width (from mul_axis_pkg)
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       async active-low reset
//  issue_i        in   1       upstream asserted multiplier en this cycle (one operand pair issued)
//  issue_ok_o     out  1       credit available; upstream may assert en next edge only when high
//  mul_valid_i    in   1       multiplier valid_o
//  mul_p_i        in   DATA_W  multiplier p_o
//  m_axis_tvalid  out  1       AXIS valid
//  m_axis_tready  in   1       AXIS ready
//  m_axis_tdata   out  DATA_W  AXIS data = product
//  m_axis_tlast   out  1       last beat of packet
//  err_o          out  1       sticky: dropped product or credit underflow
// BEHAVIOUR
//  - Reset (async assert, sync release) clears all state:
//    - issue_ok_o=1, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, err_o=0.
//    - count, inflight, beat_cnt, rd_ptr, wr_ptr all 0.
//  - Credit: issue_ok_o = (count + inflight) < DEPTH, from registers only.
//    - inflight +1 on issue_i, -1 on mul_valid_i; both in one cycle -> unchanged.
//  - Push: mul_valid_i writes mul_p_i at wr_ptr on the same edge.
//    - m_axis_tvalid rises the next cycle: 1-cycle latency valid_i -> tvalid.
//  - FIFO is first-word-fall-through:
//    - tvalid = (count != 0); tdata = mem[rd_ptr], registered.
//    - tdata and tlast hold stable while tvalid && !tready.
//  - Pop on tvalid && tready.
//    - Push and pop in one cycle: count unchanged, legal even when full.
//  - Full, push without pop: product dropped, err_o set. Never expected while credits are honoured.
//  - mul_valid_i with inflight == 0: err_o set, inflight saturates at 0, product still pushed if room.
//  - Pointers wrap modulo DEPTH.
//  - tlast = (beat_cnt == PKT_LEN-1).
//    - beat_cnt +1 per handshake; wraps to 0 after the tlast beat.
//    - PKT_LEN=1 -> tlast on every beat.
//  - Reset mid-packet discards FIFO contents and in-flight credit. The next packet starts at beat 0.
//  - err_o is cleared only by reset.
// CONFIGURATION
//  MUL_AXIS_TX_STATS_EN defined:
//    - Adds output beat_cnt_o [31:0]: total handshakes.
//    - Adds output pkt_cnt_o [15:0]: tlast handshakes.
//    - Both wrap, reset to 0, update on the edge of the handshake.
//  Undefined: these ports and counters are absent; all other behaviour identical.
// STRUCTURE
//  mul_axis_pkg holds:
//    - DATA_W=16, PIPE_LAT=3
//    - typedef logic [DATA_W-1:0] prod_t
//    - default DEPTH/PKT_LEN constants
//  Sub-module mul_axis_fifo: FWFT sync FIFO, params DEPTH and DATA_W; ports push/pop/full/empty/count.
//  Top level holds the credit counter, packet beat counter, err logic and the optional stats.
// TESTING
//  1. Reset: rst_n=0 mid-stream -> issue_ok_o=1, tvalid=0, tlast=0, err_o=0 immediately (async).
//  2. Stream, tready=1:
//     - Stimulus: 10 pairs through the multiplier, en gated by issue_ok_o:
//       (0,0) (1,255) (255,1) (128,2) (85,170) (15,15) (200,50) (7,13) (100,0) (0,150)
//     - Required beats in order: 0,255,255,256,14450,225,10000,91,0,0.
//     - With PKT_LEN=8: tlast on beat 8 only.
//  3. Backpressure:
//     - Stimulus: tready=0, issue continuously.
//     - Required: issue_ok_o drops after DEPTH=4 issues; exactly 4 beats buffered; err_o stays 0.
//     - Then tready=1: all 4 beats drain, credits return.
//  4. Simultaneous push/pop at full:
//     - Stimulus: count=4, tready=1, mul_valid_i=1 in the same cycle.
//     - Required: count stays 4; order preserved; no drop.
//  5. Error:
//     - Stimulus: mul_valid_i pulsed with no issue_i and inflight=0.
//     - Required: err_o=1 and held until reset.
//     - Stimulus: force 5 pushes with tready=0.
//     - Required: 5th product dropped.
//  6. Packet wrap, tready toggling every cycle:
//     - PKT_LEN=1 -> tlast on every beat.
//     - PKT_LEN=3 -> tlast on beats 3, 6, 9.
//     - With MUL_AXIS_TX_STATS_EN defined, after 9 beats: beat_cnt_o=9, pkt_cnt_o=3.

Source files
------------

// File: rtl/mul_axis_pkg.sv
// Shared types and constants for the multiplier AXI4-Stream transmitter.
package mul_axis_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned PIPE_LAT    = 3;
    localparam int unsigned DEF_DEPTH   = 4;
    localparam int unsigned DEF_PKT_LEN = 8;

    typedef logic [DATA_W-1:0] prod_t;

    // Counter width that stays at least one bit for a range of 1.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/mul_axis_fifo.sv
// First-word-fall-through synchronous FIFO; head entry is visible on rdata while not empty.
module mul_axis_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = mul_axis_pkg::DATA_W,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mul_axis_tx.sv
// Multiplier output transmitter: FIFO buffering, credit-based issue control, fixed-length
// AXI4-Stream packets. Define MUL_AXIS_TX_STATS_EN to add beat/packet statistics outputs.
module mul_axis_tx
    import mul_axis_pkg::*;
#(
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned PKT_LEN = DEF_PKT_LEN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_i,
    output logic        issue_ok_o,
    input  logic        mul_valid_i,
    input  prod_t       mul_p_i,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output prod_t       m_axis_tdata,
    output logic        m_axis_tlast,
`ifdef MUL_AXIS_TX_STATS_EN
    output logic [31:0] beat_cnt_o,
    output logic [15:0] pkt_cnt_o,
`endif
    output logic        err_o
);

    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W  = CNT_W + 1;
    localparam int unsigned BEAT_W = clog2_min1(PKT_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    logic [CNT_W-1:0]  fifo_count, inflight_q, inflight_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              fifo_full, fifo_empty, pop, last_beat;
    logic              err_q, err_d;
    logic [SUM_W-1:0]  occupancy;

    mul_axis_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (mul_valid_i),
        .wdata (mul_p_i),
        .pop   (pop),
        .rdata (m_axis_tdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign last_beat     = (beat_q == LAST_BEAT);
    // Gated by tvalid so tlast reads 0 out of reset even when PKT_LEN is 1.
    assign m_axis_tlast  = m_axis_tvalid && last_beat;
    // Every issued-but-unreturned product plus every buffered one must fit in the FIFO.
    assign occupancy     = SUM_W'(fifo_count) + SUM_W'(inflight_q);
    assign issue_ok_o    = (occupancy < SUM_W'(DEPTH));
    assign err_o         = err_q;

    always_comb begin
        inflight_d = inflight_q;
        if (issue_i && !mul_valid_i) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!issue_i && mul_valid_i && (inflight_q != '0)) begin
            inflight_d = inflight_q - 1'b1;
        end

        beat_d = beat_q;
        if (pop) beat_d = last_beat ? '0 : beat_q + 1'b1;

        err_d = err_q;
        if (mul_valid_i && (inflight_q == '0)) err_d = 1'b1;
        if (mul_valid_i && fifo_full && !pop)  err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
            beat_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            beat_q     <= beat_d;
            err_q      <= err_d;
        end
    end

`ifdef MUL_AXIS_TX_STATS_EN
    logic [31:0] beat_total_q;
    logic [15:0] pkt_total_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_total_q <= '0;
            pkt_total_q  <= '0;
        end else if (pop) begin
            beat_total_q <= beat_total_q + 1'b1;
            if (last_beat) pkt_total_q <= pkt_total_q + 1'b1;
        end
    end

    assign beat_cnt_o = beat_total_q;
    assign pkt_cnt_o  = pkt_total_q;
`else
    // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_mul_axis_tx.sv
// Directed bench for mul_axis_tx: three instances (PKT_LEN 8, 1, 3) share all inputs.
module tb_mul_axis_tx;
    import mul_axis_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, en, force_v, tready_drv, tog_en, tog_q, tready, mul_valid;
    logic [7:0] a, b;
    prod_t      force_p, mul_p;
    logic [2:0] v_q;
    prod_t      p_q [3];

    logic  ok [3], tv [3], tl [3], er [3];
    prod_t td [3];
`ifdef MUL_AXIS_TX_STATS_EN
    logic [31:0] bc [3];
    logic [15:0] pc [3];
`endif

    prod_t      dq [$];
    logic [2:0] lq [$];
    int         n_chk = 0;
    int         n_err = 0;

    int    va [10] = '{0, 1, 255, 128, 85, 15, 200, 7, 100, 0};
    int    vb [10] = '{0, 255, 1, 2, 170, 15, 50, 13, 0, 150};
    prod_t ve [10] = '{16'd0, 16'd255, 16'd255, 16'd256, 16'd14450, 16'd225, 16'd10000,
                       16'd91, 16'd0, 16'd0};

    always #5 clk = ~clk;

    // Behavioural 3-stage multiplier feeding the transmitter.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int i = 0; i < 3; i++) p_q[i] <= '0;
        end else begin
            v_q    <= {v_q[1:0], en};
            p_q[0] <= prod_t'(a) * prod_t'(b);
            p_q[1] <= p_q[0];
            p_q[2] <= p_q[1];
        end
    end

    always @(posedge clk) tog_q <= tog_en ? ~tog_q : 1'b0;

    assign mul_valid = v_q[2] | force_v;
    assign mul_p     = force_v ? force_p : p_q[2];
    assign tready    = tog_en ? tog_q : tready_drv;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned PL = (g == 0) ? 8 : ((g == 1) ? 1 : 3);
        mul_axis_tx #(
            .DEPTH   (4),
            .PKT_LEN (PL)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .issue_i       (en),
            .issue_ok_o    (ok[g]),
            .mul_valid_i   (mul_valid),
            .mul_p_i       (mul_p),
            .m_axis_tvalid (tv[g]),
            .m_axis_tready (tready),
            .m_axis_tdata  (td[g]),
            .m_axis_tlast  (tl[g]),
`ifdef MUL_AXIS_TX_STATS_EN
            .beat_cnt_o    (bc[g]),
            .pkt_cnt_o     (pc[g]),
`endif
            .err_o         (er[g])
        );
    end

    // Inputs are stable from posedge+1 to the next posedge, so negedge sees the coming handshake.
    always @(negedge clk) begin
        if (rst_n && tv[0] && tready) begin
            dq.push_back(td[0]);
            lq.push_back({tl[2], tl[1], tl[0]});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input int y);
        int w = 0;
        while (!ok[0] && w < 50) begin
            en = 1'b0;
            step();
            w++;
        end
        if (w >= 50) check("credit_timeout", 32'(ok[0]), 32'd1);
        en = 1'b1;
        a  = 8'(x);
        b  = 8'(y);
        step();
    endtask

    task automatic wait_beats(input int n);
        int w = 0;
        while (dq.size() < n && w < 200) begin
            step();
            w++;
        end
        check("beats_seen", 32'(dq.size()), 32'(n));
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        @(negedge clk) rst_n = 1'b1;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, issued;
        rst_n = 1'b0; en = 1'b0; a = '0; b = '0; force_v = 1'b0; force_p = '0;
        tready_drv = 1'b0; tog_en = 1'b0;
        #12;
        check("rst_issue_ok", 32'(ok[0]), 32'd1);
        check("rst_tvalid",   32'(tv[0]), 32'd0);
        check("rst_tdata",    32'(td[0]), 32'd0);
        check("rst_tlast1",   32'(tl[1]), 32'd0);
        check("rst_err",      32'(er[0]), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // Streaming with tready high.
        tready_drv = 1'b1;
        base = dq.size();
        for (int i = 0; i < 10; i++) send(va[i], vb[i]);
        en = 1'b0;
        wait_beats(base + 10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("stream_data%0d", i), 32'(dq[base+i]), 32'(ve[i]));
            check($sformatf("stream_last8_%0d", i), 32'(lq[base+i][0]), 32'(i == 7));
            check($sformatf("stream_last3_%0d", i), 32'(lq[base+i][2]), 32'(i % 3 == 2));
        end
        repeat (2) step();
        check("stream_err", 32'(er[0]), 32'd0);
        check("stream_ok",  32'(ok[0]), 32'd1);

        // Backpressure: credits run out after DEPTH issues.
        tready_drv = 1'b0;
        base   = dq.size();
        issued = 0;
        for (int c = 0; c < 10; c++) begin
            if (ok[0]) begin
                en = 1'b1; a = 8'(issued + 1); b = 8'(issued + 1); issued++;
            end else begin
                en = 1'b0;
            end
            step();
        end
        en = 1'b0;
        check("bp_issues", 32'(issued), 32'd4);
        repeat (6) step();
        check("bp_ok_low", 32'(ok[0]), 32'd0);
        check("bp_tvalid", 32'(tv[0]), 32'd1);
        check("bp_err",    32'(er[0]), 32'd0);
        check("bp_no_beats", 32'(dq.size()), 32'(base));
        tready_drv = 1'b1;
        wait_beats(base + 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("bp_data%0d", i), 32'(dq[base+i]), 32'((i + 1) * (i + 1)));
        repeat (2) step();
        check("bp_ok_back", 32'(ok[0]), 32'd1);
        check("bp_drained", 32'(tv[0]), 32'd0);

        // Push and pop together while full.
        do_reset();
        tready_drv = 1'b0;
        base = dq.size();
        for (int i = 5; i < 9; i++) send(i, i);
        en = 1'b0;
        repeat (6) step();
        check("full_ok_low", 32'(ok[0]), 32'd0);
        tready_drv = 1'b1; force_v = 1'b1; force_p = 16'hBEEF;
        step();
        tready_drv = 1'b0; force_v = 1'b0;
        check("full_still_valid", 32'(tv[0]), 32'd1);
        check("full_still_full",  32'(ok[0]), 32'd0);
        check("full_new_head",    32'(td[0]), 32'd36);
        tready_drv = 1'b1;
        wait_beats(base + 5);
        check("full_d0", 32'(dq[base]),   32'd25);
        check("full_d1", 32'(dq[base+1]), 32'd36);
        check("full_d2", 32'(dq[base+2]), 32'd49);
        check("full_d3", 32'(dq[base+3]), 32'd64);
        check("full_d4", 32'(dq[base+4]), 32'hBEEF);

        // Error: unexpected valid, then overflow of a full FIFO.
        do_reset();
        tready_drv = 1'b0;
        base = dq.size();
        check("err_clear_after_rst", 32'(er[0]), 32'd0);
        force_v = 1'b1; force_p = 16'h1111;
        step();
        force_v = 1'b0;
        check("err_underflow", 32'(er[0]), 32'd1);
        for (int i = 2; i <= 5; i++) begin
            force_v = 1'b1; force_p = prod_t'(i * 16'h1111);
            step();
        end
        force_v = 1'b0;
        repeat (3) step();
        check("err_sticky", 32'(er[0]), 32'd1);
        tready_drv = 1'b1;
        wait_beats(base + 4);
        repeat (5) step();
        check("err_dropped_count", 32'(dq.size()), 32'(base + 4));
        for (int i = 0; i < 4; i++)
            check($sformatf("err_data%0d", i), 32'(dq[base+i]), 32'((i + 1) * 16'h1111));
        check("err_held", 32'(er[0]), 32'd1);

        // Asynchronous reset while data is buffered.
        tready_drv = 1'b0;
        for (int i = 0; i < 3; i++) send(3, i + 1);
        en = 1'b0;
        repeat (4) step();
        check("mid_tvalid_before", 32'(tv[1]), 32'd1);
        check("mid_tlast1_before", 32'(tl[1]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ok",     32'(ok[0]), 32'd1);
        check("mid_rst_tvalid", 32'(tv[0]), 32'd0);
        check("mid_rst_tlast1", 32'(tl[1]), 32'd0);
        check("mid_rst_err",    32'(er[0]), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // Packet wrap with tready toggling every cycle.
        tog_en = 1'b1;
        base = dq.size();
        for (int i = 1; i <= 9; i++) send(i, 2);
        en = 1'b0;
        wait_beats(base + 9);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("wrap_data%0d", i),  32'(dq[base+i]), 32'((i + 1) * 2));
            check($sformatf("wrap_last1_%0d", i), 32'(lq[base+i][1]), 32'd1);
            check($sformatf("wrap_last3_%0d", i), 32'(lq[base+i][2]), 32'(i % 3 == 2));
            check($sformatf("wrap_last8_%0d", i), 32'(lq[base+i][0]), 32'(i == 7));
        end
        repeat (4) step();
        check("wrap_no_extra", 32'(dq.size()), 32'(base + 9));
`ifdef MUL_AXIS_TX_STATS_EN
        check("stats_beats", bc[2], 32'd9);
        check("stats_pkts3", 32'(pc[2]), 32'd3);
        check("stats_pkts1", 32'(pc[1]), 32'd9);
        check("stats_pkts8", 32'(pc[0]), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
